// File: rtl/scan_frame_buffer.sv
// rtl/scan_frame_buffer.sv - ping-pong capture of fixed-length scan frames, streamed out on valid/ready
module scan_frame_buffer #(
    parameter int POINTS = 811,
    parameter int DW     = 16,
    parameter int AW     = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cycle_enable,
    input  logic          data_in_valid,
    input  logic [DW-1:0] data_in,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic [15:0]   frame_cnt,
    output logic [15:0]   drop_cnt,
    output logic          len_err
);

    localparam int CW = AW + 1;
    localparam logic [CW-1:0] NPTS  = CW'(POINTS);
    localparam logic [CW-1:0] NSAT  = CW'(POINTS + 1);
    localparam logic [CW-1:0] NLAST = CW'(POINTS - 1);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_SKIP} wstate_t;
    typedef enum logic       {R_IDLE, R_RUN}          rstate_t;

    logic [DW-1:0] mem [0:(2**CW)-1];

    wstate_t       wstate;
    rstate_t       rstate;
    logic          cycle_enable_d;
    logic          armed;
    logic [1:0]    full;
    logic          wb;
    logic          rb;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_cnt;
    logic          rd_pend;
    logic          rd_pend_last;
    logic [DW-1:0] rd_q;
    logic          skid_valid;
    logic [DW-1:0] skid_data;
    logic          skid_last;

    logic          rise;
    logic          fall;
    logic          wr_en;
    logic          pop;
    logic          last_pop;
    logic          issue;
    logic [1:0]    level;

    // armed blocks a window that was already open when reset released
    assign rise     = cycle_enable & ~cycle_enable_d & armed;
    assign fall     = ~cycle_enable & cycle_enable_d;
    assign wr_en    = (wstate == W_FILL) & cycle_enable & data_in_valid & (wr_cnt < NPTS);
    assign pop      = m_valid & m_ready;
    assign last_pop = pop & m_last;
    assign level    = {1'b0, m_valid} + {1'b0, skid_valid} + {1'b0, rd_pend};
    // Keep output reg + skid + in-flight read within two entries
    assign issue    = (rstate == R_RUN) & (rd_cnt < NPTS) & (pop | (level < 2'd2));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wb, wr_cnt[AW-1:0]}] <= data_in;
        end
        if (issue) begin
            rd_q <= mem[{rb, rd_cnt[AW-1:0]}];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate         <= W_IDLE;
            rstate         <= R_IDLE;
            cycle_enable_d <= 1'b0;
            armed          <= ~cycle_enable;
            full           <= 2'b00;
            wb             <= 1'b0;
            rb             <= 1'b0;
            wr_cnt         <= '0;
            rd_cnt         <= '0;
            rd_pend        <= 1'b0;
            rd_pend_last   <= 1'b0;
            skid_valid     <= 1'b0;
            skid_data      <= '0;
            skid_last      <= 1'b0;
            m_valid        <= 1'b0;
            m_data         <= '0;
            m_last         <= 1'b0;
            frame_cnt      <= '0;
            drop_cnt       <= '0;
            len_err        <= 1'b0;
        end else begin
            cycle_enable_d <= cycle_enable;
            armed          <= armed | ~cycle_enable;

            case (wstate)
                W_IDLE: begin
                    if (rise) begin
                        if (!full[wb]) begin
                            wstate <= W_FILL;
                            wr_cnt <= '0;
                        end else begin
                            wstate <= W_SKIP;
                        end
                    end
                end
                W_FILL: begin
                    if (fall) begin
                        if (wr_cnt == NPTS) begin
                            full[wb] <= 1'b1;
                            wb       <= ~wb;
                        end else begin
                            len_err <= 1'b1;
                            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                        end
                        wstate <= W_IDLE;
                    end else if (cycle_enable && data_in_valid && wr_cnt != NSAT) begin
                        wr_cnt <= wr_cnt + 1'b1;
                    end
                end
                W_SKIP: begin
                    if (fall) begin
                        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                        wstate <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase

            case (rstate)
                R_IDLE: begin
                    if (full[rb]) begin
                        rstate <= R_RUN;
                        rd_cnt <= '0;
                    end
                end
                R_RUN: begin
                    if (issue) rd_cnt <= rd_cnt + 1'b1;
                    if (last_pop) begin
                        full[rb]  <= 1'b0;
                        rb        <= ~rb;
                        frame_cnt <= frame_cnt + 16'd1;
                        // Chain straight into the other bank to keep the inter-frame gap short
                        if (full[~rb]) begin
                            rd_cnt <= '0;
                        end else begin
                            rstate <= R_IDLE;
                        end
                    end
                end
                default: rstate <= R_IDLE;
            endcase

            rd_pend      <= issue;
            rd_pend_last <= issue & (rd_cnt == NLAST);

            if (pop) begin
                if (skid_valid) begin
                    m_data  <= skid_data;
                    m_last  <= skid_last;
                    m_valid <= 1'b1;
                    if (rd_pend) begin
                        skid_data <= rd_q;
                        skid_last <= rd_pend_last;
                    end else begin
                        skid_valid <= 1'b0;
                    end
                end else if (rd_pend) begin
                    m_data  <= rd_q;
                    m_last  <= rd_pend_last;
                    m_valid <= 1'b1;
                end else begin
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                end
            end else if (rd_pend) begin
                if (!m_valid) begin
                    m_valid <= 1'b1;
                    m_data  <= rd_q;
                    m_last  <= rd_pend_last;
                end else begin
                    skid_valid <= 1'b1;
                    skid_data  <= rd_q;
                    skid_last  <= rd_pend_last;
                end
            end
        end
    end

endmodule
